// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dlyc_cal_ctrl_if.sv
// Control/status bundle between the delay-line calibration sequencer and its host.
// The host drives START/ABORT, the phase detector drives EARLY, and the sequencer returns TAP and status.
interface gf180mcu_fd_sc_mcu9t5v0__dlyc_cal_ctrl_if #(
  parameter int TAP_W = 4
);
  logic             START;
  logic             ABORT;
  logic             EARLY;
  logic [TAP_W-1:0] TAP;
  logic             BUSY;
  logic             DONE;
  logic             LOCKED;
  logic             ERR;

  modport master (output START, output ABORT, output EARLY,
                  input TAP, input BUSY, input DONE, input LOCKED, input ERR);
  modport slave  (input START, input ABORT, input EARLY,
                  output TAP, output BUSY, output DONE, output LOCKED, output ERR);
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dlyc_cal_ctrl.sv
// Delay-line calibration sequencer: sweeps TAP upward and locks on the first early->late
// phase-detector transition, filtering EARLY over NSAMP consecutive agreeing samples.
module gf180mcu_fd_sc_mcu9t5v0__dlyc_cal_ctrl #(
  parameter int NTAPS  = 16,
  parameter int TAP_W  = 4,
  parameter int SETTLE = 4,
  parameter int NSAMP  = 3
) (
  input  logic                                          CLK,
  input  logic                                          RN,
  gf180mcu_fd_sc_mcu9t5v0__dlyc_cal_ctrl_if.slave       bus,
  output logic [1:0]                                    dbg_state
);
  localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int AC_W = $clog2(NSAMP + 1);
  localparam logic [SC_W-1:0]  SETTLE_LAST = SC_W'(SETTLE - 1);
  localparam logic [AC_W-1:0]  NSAMP_L     = AC_W'(NSAMP);
  localparam logic [TAP_W-1:0] TAP_MAX     = TAP_W'(NTAPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t            state, next_state;
  logic [SC_W-1:0]   settle_cnt;
  logic [AC_W-1:0]   agree_cnt, agree_next;
  logic              prev_early;
  logic [TAP_W-1:0]  tap_q, tap_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic              decide;
  logic              start_ok;

  // A run of agreeing samples restarts at 1 on any disagreement (jitter rejection).
  always_comb begin
    agree_next = AC_W'(1);
    if (agree_cnt == '0 || bus.EARLY == prev_early)
      agree_next = agree_cnt + AC_W'(1);
  end

  assign decide   = (state == ST_SAMPLE) && (agree_next == NSAMP_L);
  assign start_ok = bus.START && (state == ST_IDLE || state == ST_DONE);

  // State register plus the registered datapath.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      agree_cnt  <= '0;
      prev_early <= 1'b0;
      tap_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= next_state;
      settle_cnt <= (state == ST_SETTLE && next_state == ST_SETTLE) ? settle_cnt + SC_W'(1) : '0;
      agree_cnt  <= (state == ST_SAMPLE && next_state == ST_SAMPLE) ? agree_next : '0;
      prev_early <= (state == ST_SAMPLE) ? bus.EARLY : prev_early;
      tap_q      <= tap_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic; ABORT overrides everything else on the same edge.
  always_comb begin
    next_state = state;
    if (bus.ABORT) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (bus.START) next_state = ST_SETTLE;
        ST_SETTLE:        if (settle_cnt == SETTLE_LAST) next_state = ST_SAMPLE;
        ST_SAMPLE: begin
          if (decide)
            next_state = (prev_early_or_now() && tap_q != TAP_MAX) ? ST_SETTLE : ST_DONE;
        end
        default:          next_state = ST_IDLE;
      endcase
    end
  end

  function automatic logic prev_early_or_now();
    return bus.EARLY;
  endfunction

  // Output logic: next values of the registered outputs.
  always_comb begin
    tap_d    = tap_q;
    done_d   = done_q;
    locked_d = locked_q;
    err_d    = err_q;
    if (bus.ABORT) begin
      done_d   = 1'b0;
      locked_d = 1'b0;
      err_d    = 1'b0;
    end else if (start_ok) begin
      tap_d    = '0;
      done_d   = 1'b0;
      locked_d = 1'b0;
      err_d    = 1'b0;
    end else if (decide) begin
      if (bus.EARLY) begin
        if (tap_q != TAP_MAX) begin
          tap_d = tap_q + TAP_W'(1);
        end else begin
          err_d  = 1'b1;
          done_d = 1'b1;
        end
      end else if (tap_q != '0) begin
        locked_d = 1'b1;
        done_d   = 1'b1;
      end else begin
        // Already late at the shortest delay: the line cannot be calibrated.
        err_d  = 1'b1;
        done_d = 1'b1;
      end
    end
    busy_d = (next_state == ST_SETTLE) || (next_state == ST_SAMPLE);
  end

  assign bus.TAP    = tap_q;
  assign bus.BUSY   = busy_q;
  assign bus.DONE   = done_q;
  assign bus.LOCKED = locked_q;
  assign bus.ERR    = err_q;
  assign dbg_state  = state;
endmodule
